// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit frame shifter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  localparam int   MAX_FRAME = 13;
  localparam int   CNT_W     = 4;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_piso_reg.sv
// Generic parallel-in/serial-out register, LSB out first, refills from sdi_i.
module uart_piso_reg #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_i,
  input  logic             sh_i,
  input  logic             sdi_i,
  input  logic [WIDTH-1:0] pdata_i,
  output logic             so_o
);

  logic [WIDTH-1:0] q_q;

  // Load wins over shift; idle contents are all ones so the line stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '1;
    end else if (ld_i) begin
      q_q <= pdata_i;
    end else if (sh_i) begin
      q_q <= {sdi_i, q_q[WIDTH-1:1]};
    end else begin
      q_q <= q_q;
    end
  end

  assign so_o = q_q[0];

endmodule

// File: rtl/uart_tx_frame_shifter.sv
// UART TX frame serializer: start, DATA_BITS data LSB-first, optional parity, 1/2 stops.
// Optional line-break input enabled by defining UART_TX_BREAK_EN.
module uart_tx_frame_shifter
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 par_en,
  input  logic                 par_odd,
  input  logic                 two_stop,
  input  logic                 bit_tick,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk,
`endif
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 sdo
);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 sdo_q;

  logic                 brk_s;
  logic                 accept_s;
  logic                 shift_s;
  logic                 piso_so_s;
  logic [MAX_FRAME-1:0] frame_s;
  logic [CNT_W-1:0]     len_s;

  function automatic logic parity_f(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

`ifdef UART_TX_BREAK_EN
  assign brk_s = brk;
`else
  assign brk_s = 1'b0;
`endif

  assign accept_s = load && ready_q && !brk_s && (state_q == ST_IDLE);
  assign len_s    = CNT_W'(DATA_BITS + 2) + CNT_W'(par_en) + CNT_W'(two_stop);

  // The register pops one bit each time sdo is updated, so it runs one bit ahead of the line.
  assign shift_s  = bit_tick && ((state_q == ST_ARM) ||
                                 ((state_q == ST_SHIFT) && (cnt_q > CNT_W'(1))));

  // Frame image: start bit, payload, optional parity; everything above stays high.
  always_comb begin
    frame_s              = '1;
    frame_s[0]           = 1'b0;
    frame_s[DATA_BITS:1] = data;
    if (par_en) begin
      frame_s[DATA_BITS+1] = parity_f(data, par_odd);
    end else begin
      frame_s[DATA_BITS+1] = LINE_IDLE;
    end
  end

  uart_piso_reg #(
    .WIDTH (MAX_FRAME)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .ld_i    (accept_s),
    .sh_i    (shift_s),
    .sdi_i   (LINE_IDLE),
    .pdata_i (frame_s),
    .so_o    (piso_so_s)
  );

  // Frame sequencing with registered line and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sdo_q   <= LINE_IDLE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q <= ST_ARM;
            cnt_q   <= len_s;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            sdo_q   <= LINE_IDLE;
          end else begin
            ready_q <= !brk_s;
            busy_q  <= 1'b0;
            sdo_q   <= brk_s ? ~LINE_IDLE : LINE_IDLE;
          end
        end
        ST_ARM: begin
          if (bit_tick) begin
            state_q <= ST_SHIFT;
            sdo_q   <= piso_so_s;
          end else begin
            sdo_q   <= LINE_IDLE;
          end
        end
        ST_SHIFT: begin
          if (bit_tick) begin
            if (cnt_q > CNT_W'(1)) begin
              cnt_q <= cnt_q - CNT_W'(1);
              sdo_q <= piso_so_s;
            end else begin
              // ready stays low this cycle so no load can coincide with done.
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b0;
              sdo_q   <= LINE_IDLE;
            end
          end else begin
            sdo_q <= sdo_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          sdo_q   <= LINE_IDLE;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sdo   = sdo_q;

endmodule

// File: doc/uart_tx_frame_shifter.md
Name: uart_tx_frame_shifter

Overview:
Parametrised UART transmit frame serializer that builds and shifts out the full frame: start bit, DATA_BITS data bits LSB-first, optional parity, and 1 or 2 stop bits. Frame options are selected at run time.
- Sits between the TX FIFO or holding register and the serial pin.
- Paced by a one-cycle bit_tick strobe from the baud generator.
- Uses a valid/ready load handshake and reports completion with a done pulse.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
MAX_FRAME, 13, shift register width (1 start + 9 data + 1 parity + 2 stop); fixed, not for override.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
load  in  1  frame request; accepted when load && ready
data  in  DATA_BITS  payload, sampled on the accepting cycle
par_en  in  1  include a parity bit; sampled at accept
par_odd  in  1  1 = odd parity, 0 = even; sampled at accept
two_stop  in  1  1 = two stop bits; sampled at accept
bit_tick  in  1  one-cycle strobe, one per bit period
ready  out  1  high only in IDLE
busy  out  1  high in ARM and SHIFT
done  out  1  one-cycle pulse when the last stop bit period ends
sdo  out  1  serial output, idle-high

Behaviour:
- Reset (async, rst=1): state=IDLE, shift register all 1s, bit count=0, sdo=1, ready=1, busy=0, done=0. A frame in flight is discarded and the line returns high immediately.
- Frame length: len = 1 + DATA_BITS + par_en + 1 + two_stop. Bit counter is 4 bits wide.
- Parity bit: ^data XOR par_odd. Even parity makes the total count of 1s even.
- Shift register load: bits [0] = 0 (start), then data LSB-first, then parity if enabled, then stop bit(s) = 1. All unused upper bits = 1.
- State IDLE:
  - sdo=1, ready=1.
  - On load: capture the frame, set cnt=len, go to ARM.
  - bit_tick in the same cycle as load is ignored.
- State ARM:
  - sdo=1, busy=1.
  - Waits for the next bit_tick, then goes to SHIFT. This aligns the start bit to a full bit period.
- State SHIFT:
  - sdo = shift_reg[0].
  - On bit_tick with cnt>1: shift right, fill MSB with 1, decrement cnt.
  - On bit_tick with cnt==1: go to IDLE, pulse done for one cycle, sdo=1.
- Bit timing: each frame bit is held exactly one bit_tick period. Total frame time = len tick periods after ARM exits.
- load while busy: ignored, with no effect on the frame in flight.
- A new load in the same cycle that done pulses is not possible, because ready only rises in the next cycle.
- Back-to-back frames: the earliest accept is the cycle after done. The ARM wait then guarantees no truncated start bit.
- sdo is registered: glitch-free, one-cycle latency from a state change.

Optional Feature:
UART_TX_BREAK_EN
- Defined:
  - Adds input port brk (1 bit).
  - brk=1 while in IDLE forces sdo=0 and ready=0; load is not accepted.
  - brk asserted during ARM or SHIFT takes effect only once the frame completes.
  - Releasing brk returns sdo=1 on the next cycle.
- Undefined: no brk port. Line behaviour exactly as in Behaviour.

Decomposition:
- Package uart_pkg:
  - state encoding constants ST_IDLE, ST_ARM, ST_SHIFT.
  - MAX_FRAME=13 and the counter width constant CNT_W=4.
  - Idle line level constant LINE_IDLE=1.
- Sub-module uart_piso_reg: generic parametrised-width PISO register.
  - Inputs: WIDTH, LD, SH, SDI, parallel load vector.
  - Reset value all 1s; LD has priority over SH.
- The FSM, counter and parity stay in the top-level block.

Test Plan:
- DATA_BITS=8, par_en=0, two_stop=0, load data=8'hA5 → after ARM, sdo per tick = 0,1,0,1,0,0,1,0,1,1. done pulses once after the 10th tick, then ready=1.
- par_en=1, par_odd=0, data=8'h07 → sdo = 0,1,1,1,0,0,0,0,0,1(parity),1(stop); 11 ticks.
- par_en=1, par_odd=1, two_stop=1, data=8'h03 → parity bit=1, two stop 1s, done after 12 ticks.
- load pulsed with data=8'hFF at tick 4 of an 8'h00 frame → ignored; sdo continues the 8'h00 sequence and no second frame follows.
- rst asserted mid-SHIFT (sdo=0) → sdo=1, busy=0, ready=1 asynchronously. After release, a new load of 8'h55 transmits correctly.
- UART_TX_BREAK_EN defined, brk=1 in IDLE for 20 ticks → sdo=0 and ready=0 throughout. After brk=0, sdo=1 on the next cycle.
